series_sched: RTL and testbench
===============================

Name: series_sched

Overview:
Round-robin scheduler that shares one Maclaurin series engine (cos/sin/exp evaluator with start/done handshake) between NREQ independent requesters. It arbitrates requests, latches the winner's operand and function code, and pulses the engine start. It then waits for the engine's done with a watchdog timeout and returns the result tagged with the requester index. It sits between the application-side clients and the series engine top level.

Parameters:
NREQ, 4, number of requesters (2..8)
XW, 16, operand width (matches engine xBus)
RW, 18, result width (matches engine rBus)
TMO, 64, watchdog limit in cycles spent in WAIT before error (>=2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req  in  NREQ  per-requester request level; held high with func/x stable until ack
func  in  2*NREQ  per-requester function code, slice i = bits [2i+1:2i]; 00 cos, 01 sin, 10 exp, 11 reserved
x_in  in  XW*NREQ  per-requester operand, slice i = bits [XW*i+XW-1:XW*i]
ack  out  NREQ  one-cycle grant/accept pulse to the selected requester
res_valid  out  1  one-cycle result strobe
res_id  out  3  index of requester owning the result
res_data  out  RW  result value, valid with res_valid
res_err  out  1  with res_valid: timeout or reserved function code
busy  out  1  high in any state other than IDLE
eng_start  out  1  one-cycle start pulse to engine
eng_func  out  2  latched function code to engine
eng_x  out  XW  latched operand to engine, stable from ISSUE until return to IDLE
eng_done  in  1  engine completion (level or pulse; first high cycle in WAIT counts)
eng_r  in  RW  engine result, sampled on the cycle eng_done is high in WAIT

Behaviour:
- Reset: state IDLE; ack, res_valid, res_err, eng_start, busy = 0; res_id, res_data, eng_func, eng_x = 0; rr pointer = NREQ-1, so requester 0 wins first; timer = 0. Reset mid-job abandons the job with no result; eng_start is held low; a later eng_done seen in IDLE is ignored.
- FSM states: IDLE, ISSUE, WAIT, DELIVER. All outputs are registered or decoded from state and registers; none depend combinationally on req.
- IDLE: if any req bit is set, select the first set bit searching ptr+1, ptr+2, ... modulo NREQ. Latch id, func[id] into eng_func and x_in[id] into eng_x, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE (1 cycle): ack[id] = 1. If eng_func != 11, eng_start = 1 and go to WAIT with timer cleared. If eng_func == 11, there is no start; set res_data = 0 and res_err = 1, then go to DELIVER.
- WAIT: eng_done is ignored during ISSUE and counted only in WAIT.
  - eng_done = 1: res_data <= eng_r, res_err <= 0, go to DELIVER.
  - Otherwise timer++. When timer reaches TMO-1 without done, res_data <= 0, res_err <= 1, go to DELIVER.
  - eng_done on the same cycle as the timeout takes priority, so the result is returned without error.
- DELIVER (1 cycle): res_valid = 1, res_id = id, ptr <= id, go to IDLE. There is no back-pressure; the consumer must accept the strobe.
- Latency: req seen in IDLE at cycle 0 gives ack and eng_start at cycle 1. Engine done at cycle k >= 2 gives res_valid at cycle k+1. The earliest re-arbitration is the cycle after DELIVER.
- Requester rules: a requester may drop req or change operands from the cycle after its ack. A req that stays high after ack is treated as a new request at the next IDLE. Requesters not granted keep req high; they are never dropped.
- Fairness: a continuously requesting client waits at most NREQ-1 jobs.
- req changes during ISSUE, WAIT or DELIVER do not affect the job in flight.
- One job in flight at most; ack is one-hot or zero.

Test Plan:
- Single job: engine model returns done 10 cycles after start with eng_r=18'h1F000. req[2]=1, func=00, x=16'h4000 → ack[2] and eng_start at cycle 1 with eng_x=4000, eng_func=00; res_valid at cycle 12 with res_id=2, res_data=1F000, res_err=0.
- Round-robin: req=4'b1111 held continuously, engine 5-cycle latency → grants in order 0,1,2,3,0; each ack is one-hot; no requester is skipped.
- Timeout: engine never asserts done, TMO=64 → res_valid with res_err=1, res_data=0, after 64 WAIT cycles; next pending request is served normally afterwards.
- Reserved function: req[1]=1, func=11 → ack[1] with eng_start never asserted; res_valid the following cycle with res_err=1, res_id=1.
- Done/timeout collision: done on WAIT cycle TMO → res_err=0 and data captured. Stray eng_done pulses in IDLE/ISSUE → no res_valid.
- Reset mid-WAIT: assert rst for 1 cycle → all outputs 0, busy=0; a late eng_done is ignored; the next req[3] job completes normally, with requester 0 having priority if it is also requesting.

Source files
------------

// File: rtl/series_sched.sv
`default_nettype none
// ============================================================================
//  Module      : series_sched
//  Description : Round-robin front end that shares one Maclaurin series
//                engine (cos/sin/exp) between NREQ requesters. A winner is
//                picked in IDLE, its function code and operand are latched
//                and the engine is started. A watchdog bounds the wait for
//                the engine's done. The result (or an error) is then
//                returned, tagged with the requester index.
//
//  Ports
//    clk        : clock, all logic on the rising edge
//    rst        : synchronous active-high reset
//    req        : per-requester request level (held until ack)
//    func       : per-requester function code, 2 bits per requester
//                 (00 cos, 01 sin, 10 exp, 11 reserved)
//    x_in       : per-requester operand, XW bits per requester
//    ack        : one-cycle accept pulse, one-hot or zero
//    res_valid  : one-cycle result strobe
//    res_id     : requester index that owns the result
//    res_data   : result value, qualified by res_valid
//    res_err    : with res_valid, timeout or reserved function code
//    busy       : high whenever a job is in flight
//    eng_start  : one-cycle engine start pulse
//    eng_func   : latched function code to the engine
//    eng_x      : latched operand to the engine
//    eng_done   : engine completion, only honoured while waiting
//    eng_r      : engine result, sampled together with eng_done
//
//  Revision    : 1.0  initial release
// ============================================================================
module series_sched #(
    parameter int NREQ = 4,
    parameter int XW   = 16,
    parameter int RW   = 18,
    parameter int TMO  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    func,
    input  logic [XW*NREQ-1:0]   x_in,
    output logic [NREQ-1:0]      ack,
    output logic                 res_valid,
    output logic [2:0]           res_id,
    output logic [RW-1:0]        res_data,
    output logic                 res_err,
    output logic                 busy,
    output logic                 eng_start,
    output logic [1:0]           eng_func,
    output logic [XW-1:0]        eng_x,
    input  logic                 eng_done,
    input  logic [RW-1:0]        eng_r
);

    // Timer counts WAIT cycles 0..TMO-1; the last value is the timeout point.
    localparam int TW = $clog2(TMO);

    localparam logic [1:0]    C_IDLE     = 2'd0;
    localparam logic [1:0]    C_ISSUE    = 2'd1;
    localparam logic [1:0]    C_WAIT     = 2'd2;
    localparam logic [1:0]    C_DELIVER  = 2'd3;

    localparam logic [1:0]    C_FN_RSV   = 2'b11;
    localparam logic [TW-1:0] C_TMO_LAST = TW'(TMO - 1);
    // Pointer starts at the last requester so requester 0 wins first.
    localparam logic [2:0]    C_PTR_RST  = 3'(NREQ - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_next;
    logic [2:0]    r_id;
    logic [2:0]    r_ptr;
    logic [1:0]    r_func;
    logic [XW-1:0] r_x;
    logic [RW-1:0] r_data;
    logic          r_err;
    logic [TW-1:0] r_timer;

    logic          w_any;
    logic [2:0]    w_sel;
    logic          w_rsv;
    logic          w_tmo;

    assign w_rsv = (r_func == C_FN_RSV);
    assign w_tmo = (r_timer == C_TMO_LAST);

    // ------------------------------------------------------------------
    // Rotating priority search: the first set request at ptr+1, ptr+2, ...
    // modulo NREQ. Outer loop walks the rotation distance, inner loop
    // matches that distance to a constant requester index so every
    // select stays a constant bit select.
    // ------------------------------------------------------------------
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!w_any && req[i] && (((int'(r_ptr) + k) % NREQ) == i)) begin
                    w_any = 1'b1;
                    w_sel = 3'(i);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            C_IDLE:    if (w_any) w_next = C_ISSUE;
            C_ISSUE:   w_next = w_rsv ? C_DELIVER : C_WAIT;
            // done and timeout in the same cycle both lead to DELIVER;
            // the datapath gives done priority for the result value.
            C_WAIT:    if (eng_done || w_tmo) w_next = C_DELIVER;
            C_DELIVER: w_next = C_IDLE;
            default:   w_next = C_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers: job latch, watchdog, result capture, pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id    <= '0;
            r_ptr   <= C_PTR_RST;
            r_func  <= '0;
            r_x     <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_timer <= '0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    if (w_any) begin
                        r_id <= w_sel;
                        for (int i = 0; i < NREQ; i++) begin
                            if (w_sel == 3'(i)) begin
                                r_func <= func[2*i +: 2];
                                r_x    <= x_in[XW*i +: XW];
                            end
                        end
                    end
                end
                C_ISSUE: begin
                    r_timer <= '0;
                    // Reserved code never reaches the engine.
                    if (w_rsv) begin
                        r_data <= '0;
                        r_err  <= 1'b1;
                    end
                end
                C_WAIT: begin
                    if (eng_done) begin
                        r_data <= eng_r;
                        r_err  <= 1'b0;
                    end else if (w_tmo) begin
                        r_data <= '0;
                        r_err  <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                C_DELIVER: begin
                    // The served requester becomes lowest priority next.
                    r_ptr <= r_id;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state and registers only, never from req
    // ------------------------------------------------------------------
    always_comb begin
        ack = '0;
        for (int i = 0; i < NREQ; i++) begin
            ack[i] = (r_state == C_ISSUE) && (r_id == 3'(i));
        end
        eng_start = (r_state == C_ISSUE) && !w_rsv;
        res_valid = (r_state == C_DELIVER);
        busy      = (r_state != C_IDLE);
        res_id    = r_id;
        res_data  = r_data;
        res_err   = r_err;
        eng_func  = r_func;
        eng_x     = r_x;
    end

endmodule
`default_nettype wire

// File: tb/tb_series_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_series_sched
//  Description : Self-checking bench for series_sched. Requesters and a
//                reactive engine are driven with $urandom stimulus; a
//                transaction-level model predicts grant order and the
//                cycle and content of every ack/start/result.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_series_sched;

    localparam int NREQ  = 4;
    localparam int XW    = 16;
    localparam int RW    = 18;
    localparam int TMO   = 64;
    localparam int NEVER = 1000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [2*NREQ-1:0]    func;
    logic [XW*NREQ-1:0]   x_in;
    logic [NREQ-1:0]      ack;
    logic                 res_valid;
    logic [2:0]           res_id;
    logic [RW-1:0]        res_data;
    logic                 res_err;
    logic                 busy;
    logic                 eng_start;
    logic [1:0]           eng_func;
    logic [XW-1:0]        eng_x;
    logic                 eng_done;
    logic [RW-1:0]        eng_r;

    series_sched #(.NREQ(NREQ), .XW(XW), .RW(RW), .TMO(TMO)) u_dut (
        .clk(clk), .rst(rst), .req(req), .func(func), .x_in(x_in),
        .ack(ack), .res_valid(res_valid), .res_id(res_id),
        .res_data(res_data), .res_err(res_err), .busy(busy),
        .eng_start(eng_start), .eng_func(eng_func), .eng_x(eng_x),
        .eng_done(eng_done), .eng_r(eng_r)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_checks = 0;
    int cyc = 0;
    bit prev_rst = 1'b1;

    // requester side
    bit            rq_on [NREQ];
    logic [1:0]    rq_f  [NREQ];
    logic [XW-1:0] rq_x  [NREQ];

    // knobs
    bit gen_rand = 1'b0;
    bit allow_rsv = 1'b1;
    bit stray_en = 1'b0;
    int keep_mode = 0;      // 0 drop after ack, 1 keep, 2 random
    int fixed_lat = 0;
    int lat_q[$];
    logic [RW-1:0] r_q[$];

    // reference model of the job in flight
    int m_ptr = NREQ - 1;
    int m_free = 0;
    int m_ack_cyc = -1;
    int m_res_cyc = -1;
    int m_id = 0;
    bit m_started = 1'b0;
    logic [1:0]    m_f;
    logic [XW-1:0] m_x;
    logic [RW-1:0] m_r;
    logic [RW-1:0] m_data;
    logic          m_err;
    int m_lat = -1;

    // engine model
    int eng_done_at = -1;
    logic [RW-1:0] eng_val;

    int grants[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (ptr + k) % NREQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [1:0] rand_func();
        return allow_rsv ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
    endfunction

    task automatic check_cycle();
        logic [NREQ-1:0] ea;
        bit issue;
        issue = (cyc == m_ack_cyc);
        ea = '0;
        if (issue) ea[m_id] = 1'b1;
        if (prev_rst) begin
            check_val("rst_res_id",   res_id,   0);
            check_val("rst_res_data", res_data, 0);
            check_val("rst_res_err",  res_err,  0);
            check_val("rst_eng_func", eng_func, 0);
            check_val("rst_eng_x",    eng_x,    0);
        end
        check_val("ack",       ack,       ea);
        check_val("eng_start", eng_start, issue && (m_f != 2'd3));
        check_val("res_valid", res_valid, cyc == m_res_cyc);
        check_val("busy",      busy,      m_ack_cyc >= 0 && cyc >= m_ack_cyc && cyc <= m_res_cyc);
        if (issue) begin
            check_val("eng_func", eng_func, m_f);
            check_val("eng_x",    eng_x,    m_x);
        end
        if (cyc == m_res_cyc) begin
            check_val("res_id",   res_id,   m_id);
            check_val("res_data", res_data, m_data);
            check_val("res_err",  res_err,  m_err);
        end
        // engine reacts to what the DUT actually does
        if (eng_start) begin
            eng_done_at = (m_lat < 0) ? -1 : cyc + m_lat;
            eng_val     = m_r;
        end
        // requester handshake on observed acks
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) begin
                grants.push_back(i);
                if (keep_mode == 1 || (keep_mode == 2 && $urandom_range(0, 1) == 1)) begin
                    rq_f[i] = rand_func();
                    rq_x[i] = XW'($urandom);
                end else begin
                    rq_on[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic plan_job();
        int lat;
        m_id = rr_pick(m_ptr, req);
        m_f = rq_f[m_id];
        m_x = rq_x[m_id];
        m_ack_cyc = cyc + 1;
        m_ptr = m_id;
        if (m_f == 2'd3) begin
            m_started = 1'b0;
            m_lat = -1;
            m_res_cyc = cyc + 2;
            m_data = '0;
            m_err = 1'b1;
        end else begin
            m_started = 1'b1;
            if (lat_q.size() > 0) lat = lat_q.pop_front();
            else if (fixed_lat > 0) lat = fixed_lat;
            else begin
                case ($urandom_range(0, 15))
                    0:       lat = TMO;
                    1:       lat = NEVER;
                    default: lat = $urandom_range(1, 12);
                endcase
            end
            m_r = (r_q.size() > 0) ? r_q.pop_front() : RW'($urandom);
            if (lat <= TMO) begin
                m_lat = lat;
                m_res_cyc = cyc + 1 + lat + 1;
                m_data = m_r;
                m_err = 1'b0;
            end else begin
                m_lat = -1;
                m_res_cyc = cyc + 1 + TMO + 1;
                m_data = '0;
                m_err = 1'b1;
            end
        end
        m_free = m_res_cyc + 1;
    endtask

    task automatic drive_cycle(input bit r);
        bit in_wait;
        rst = r;
        if (gen_rand) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!rq_on[i] && $urandom_range(0, 3) == 0) begin
                    rq_on[i] = 1'b1;
                    rq_f[i] = rand_func();
                    rq_x[i] = XW'($urandom);
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            req[i] = rq_on[i];
            func[2*i +: 2]  = rq_on[i] ? rq_f[i] : 2'($urandom);
            x_in[XW*i +: XW] = rq_on[i] ? rq_x[i] : XW'($urandom);
        end
        if (r) begin
            m_ack_cyc = -1;
            m_res_cyc = -1;
            m_started = 1'b0;
            m_ptr = NREQ - 1;
            m_free = cyc + 1;
        end else if (cyc >= m_free && req != '0) begin
            plan_job();
        end
        in_wait = m_started && cyc > m_ack_cyc && cyc < m_res_cyc;
        eng_done = (cyc == eng_done_at);
        eng_r = eng_done ? eng_val : RW'($urandom);
        if (stray_en && !in_wait && $urandom_range(0, 5) == 0) eng_done = 1'b1;
        prev_rst = r;
    endtask

    task automatic step(input bit r);
        @(posedge clk);
        #1;
        cyc++;
        check_cycle();
        drive_cycle(r);
    endtask

    task automatic do_reset();
        for (int i = 0; i < NREQ; i++) rq_on[i] = 1'b0;
        lat_q.delete();
        r_q.delete();
        fixed_lat = 0;
        gen_rand = 1'b0;
        stray_en = 1'b0;
        keep_mode = 0;
        allow_rsv = 1'b1;
        eng_done_at = -1;
        step(1'b1);
        step(1'b1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int late;
        rst = 1'b1;
        req = '0;
        func = '0;
        x_in = '0;
        eng_done = 1'b0;
        eng_r = '0;
        for (int i = 0; i < NREQ; i++) begin
            rq_on[i] = 1'b0;
            rq_f[i] = '0;
            rq_x[i] = '0;
        end

        // single job, 10-cycle engine
        do_reset();
        rq_on[2] = 1'b1; rq_f[2] = 2'b00; rq_x[2] = 16'h4000;
        lat_q.push_back(10);
        r_q.push_back(18'h1F000);
        run(20);

        // round robin with all requesters held high
        do_reset();
        allow_rsv = 1'b0;
        keep_mode = 1;
        fixed_lat = 5;
        for (int i = 0; i < NREQ; i++) begin
            rq_on[i] = 1'b1; rq_f[i] = rand_func(); rq_x[i] = XW'($urandom);
        end
        grants.delete();
        for (int t = 0; t < 200 && grants.size() < 5; t++) step(1'b0);
        check_val("rr_grant_count", grants.size(), 5);
        for (int k = 0; k < 5 && k < grants.size(); k++)
            check_val("rr_order", grants[k], k % NREQ);

        // timeout, then the next pending request is served normally
        do_reset();
        rq_on[1] = 1'b1; rq_f[1] = 2'b10; rq_x[1] = XW'($urandom);
        rq_on[3] = 1'b1; rq_f[3] = 2'b01; rq_x[3] = XW'($urandom);
        lat_q.push_back(NEVER);
        lat_q.push_back(7);
        run(TMO + 30);

        // reserved function code
        do_reset();
        rq_on[1] = 1'b1; rq_f[1] = 2'b11; rq_x[1] = XW'($urandom);
        run(8);

        // done on the very last WAIT cycle, stray done pulses outside WAIT
        do_reset();
        stray_en = 1'b1;
        rq_on[0] = 1'b1; rq_f[0] = 2'b01; rq_x[0] = XW'($urandom);
        lat_q.push_back(TMO);
        run(TMO + 20);

        // reset in the middle of WAIT; the late done must be ignored
        do_reset();
        rq_on[3] = 1'b1; rq_f[3] = 2'b00; rq_x[3] = XW'($urandom);
        lat_q.push_back(30);
        for (int t = 0; t < 20 && !(m_ack_cyc > 0 && cyc >= m_ack_cyc + 5); t++) step(1'b0);
        late = eng_done_at;
        step(1'b1);
        for (int t = 0; t < 60 && cyc <= late + 1; t++) step(1'b0);
        grants.delete();
        fixed_lat = 4;
        rq_on[0] = 1'b1; rq_f[0] = 2'b10; rq_x[0] = XW'($urandom);
        rq_on[3] = 1'b1; rq_f[3] = 2'b00; rq_x[3] = XW'($urandom);
        run(30);
        check_val("post_rst_grant_count", grants.size(), 2);
        if (grants.size() >= 2) begin
            check_val("post_rst_first",  grants[0], 0);
            check_val("post_rst_second", grants[1], 3);
        end

        // randomized traffic
        do_reset();
        gen_rand = 1'b1;
        stray_en = 1'b1;
        keep_mode = 2;
        run(3000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
